reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
// 2-wide in-order reorder buffer, directly downstream of register_renamer in the IF/DE/R pipeline.
// Allocates up to 2 renamed instrs/cycle in program order, accepts up to 2 out-of-order completions/cycle,
// and retires up to 2 completed instrs/cycle from the head.
// Retire drives the renamer free ports (en_free_reg0/1_i, free_reg0/1_i) with old_dest of each retiring instr.
// PARAMETERS
// NUM_ROB_ENTRIES  16  entry count; power of 2, >=4; IDX_W = $clog2(NUM_ROB_ENTRIES)
// NUM_A_REGS       32  architectural regs; AREG_W = 5
// NUM_P_REGS       64  physical regs; PREG_W = 6
// WORD_SIZE        32  result width
// PORTS   (x = 0,1; slot 0 is older)
// clk_i               in   1        clock, rising edge
// rst_ni              in   1        asynchronous, active-low reset
// flush_i             in   1        sync clear of all entries
// alloc_ready_o       out  1        >=2 free entries (registered count)
// allocx_valid_i      in   1        allocate request, slot x
// allocx_regwrite_i   in   1        instr writes rd
// allocx_rd_i         in   AREG_W   arch dest
// allocx_p_dest_i     in   PREG_W   new physical dest
// allocx_old_dest_i   in   PREG_W   previous mapping of rd
// allocx_idx_o        out  IDX_W    ROB index given to slot x (comb.)
// cmplx_valid_i       in   1        completion strobe
// cmplx_idx_i         in   IDX_W    completing entry
// cmplx_val_i         in   WORD_SIZE result
// commitx_valid_o     out  1        slot x retires this cycle (comb.)
// commitx_free_en_o   out  1        commitx_valid_o & regwrite
// commitx_free_preg_o out  PREG_W   old_dest to free
// commitx_rd_o        out  AREG_W   retiring arch dest (trace)
// commitx_val_o       out  WORD_SIZE retiring result (trace)
// fwdx_idx_i          in   IDX_W    lookup index
// fwdx_ready_o        out  1        entry valid & done (comb.)
// fwdx_val_o          out  WORD_SIZE entry result (comb.)
// count_o             out  IDX_W+1  occupied entries (registered)
// BEHAVIOUR
// - Entry = {valid, done, regwrite, rd, p_dest, old_dest, val}.
//   head/tail are IDX_W+1 bits incl. wrap bit; index = low IDX_W bits.
// - Reset (rst_ni=0, async): all valid/done=0, head=tail=0, count=0.
//   Outputs: alloc_ready_o=1, count_o=0, all commit*/fwd*_ready_o=0.
// - alloc_ready_o = (NUM_ROB_ENTRIES - count) >= 2.
//   Same-cycle retires are not credited. Alloc requests while !alloc_ready_o are dropped; upstream stalls.
// - Alloc: alloc0_idx_o = tail; alloc1_idx_o = tail + alloc0_valid_i (slot 1 compacts into slot 0's place).
//   At posedge, valid slots written with valid=1, done=0; tail += nalloc.
// - Completion: at posedge, entry[cmplx_idx_i] gets done=1, val=cmplx_val_i, only if entry valid.
//   Completion to an invalid entry (incl. one allocated the same edge) is ignored.
//   Both ports on the same idx: port 1 wins.
// - Commit (comb.): commit0_valid_o = E[head].valid & E[head].done;
//   commit1_valid_o = commit0_valid_o & E[head+1].valid & E[head+1].done.
//   At posedge, retired entries are cleared, head += ncommit. Never retires past tail; empty -> no commit.
// - count_next = count + nalloc - ncommit. Simultaneous alloc+commit allowed, including at full/wrap.
// - Latency: alloc at edge E0, earliest completion edge E1 = E0+1;
//   commit_valid_o visible after E1; retire at E2. Completion is not bypassed to same-cycle commit.
// - fwd lookups are comb. from stored state; same-cycle completion is not bypassed.
// - flush_i: at posedge, same effect as reset; it overrides alloc/cmpl that cycle.
//   While flush_i=1, commit*_valid_o and free_en are forced 0.
// - Wrap: pointers wrap modulo 2*NUM_ROB_ENTRIES.
//   full = (idx equal & wrap bits differ); empty = (head == tail).
// STRUCTURE
// - riscv_pkg: rob_entry_t struct, ROB_IDX_W/PREG_W/AREG_W constants; rob_fwd_table_entry moves here too.
// - One sub-module: rob_commit_select (comb.; head entries -> commit0/1 valid + ncommit).
// - Entry storage, pointers and count stay in the top module.
// TESTING
// - Reset mid-run with 5 entries live -> count_o=0, alloc_ready_o=1, no commit until new allocs complete.
// - Alloc 2 (p_dest 33,34; old 3,4), complete idx1 then idx0 -> nothing retires until idx0 done;
//   both retire the next cycle, free_preg 3,4.
// - Fill 16 entries -> alloc_ready_o=0 at count 15, 16th alloc dropped when count=15 and 2 requested, count_o=15.
// - head=14, tail=2 (wrapped), all done -> retire 2/cycle; indices 14,15,0,1 retire in order; count_o reaches 0.
// - alloc0_valid=0, alloc1_valid=1 -> alloc1_idx_o = tail; same-idx double completion -> val from port 1.
// - flush_i with 6 live entries and cmpl0 strobe -> commit outputs 0 that cycle; next cycle count_o=0, head=tail=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and default widths for the reorder buffer and its neighbours.
package riscv_pkg;

  localparam int ROB_IDX_W = 4;   // 16 entries by default
  localparam int AREG_W    = 5;   // 32 architectural registers
  localparam int PREG_W    = 6;   // 64 physical registers
  localparam int XLEN      = 32;  // result width

  // One ROB entry at the default widths.
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              regwrite;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] p_dest;
    logic [PREG_W-1:0] old_dest;
    logic [XLEN-1:0]   val;
  } rob_entry_t;

  // What a forwarding lookup into the ROB returns.
  typedef struct packed {
    logic            ready;
    logic [XLEN-1:0] val;
  } rob_fwd_table_entry_t;

  // Number of set bits in a 2-slot request vector.
  function automatic logic [1:0] slot_count(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Decides how many head entries retire this cycle (0, 1 or 2, strictly in order).
module rob_commit_select
  import riscv_pkg::*;
(
  input  logic       flush_i,
  input  logic       empty_i,
  input  logic [1:0] head_valid_i,
  input  logic [1:0] head_done_i,
  output logic [1:0] commit_valid_o,
  output logic [1:0] ncommit_o
);

  logic c0;
  logic c1;

  // Slot 1 may only retire when slot 0 does; flush or an empty ROB blocks both.
  always_comb begin
    c0 = 1'b0;
    c1 = 1'b0;
    if (!flush_i && !empty_i) begin
      c0 = head_valid_i[0] & head_done_i[0];
      c1 = c0 & head_valid_i[1] & head_done_i[1];
    end
    commit_valid_o = {c1, c0};
    ncommit_o      = slot_count({c1, c0});
  end

endmodule

// File: rtl/reorder_buffer.sv
// 2-wide in-order reorder buffer: in-order allocate, out-of-order complete, in-order retire.
module reorder_buffer
  import riscv_pkg::*;
#(
  parameter int NUM_ROB_ENTRIES = 2 ** ROB_IDX_W,
  parameter int NUM_A_REGS      = 2 ** AREG_W,
  parameter int NUM_P_REGS      = 2 ** PREG_W,
  parameter int WORD_SIZE       = XLEN,
  localparam int IDX_W = $clog2(NUM_ROB_ENTRIES),
  localparam int AW    = $clog2(NUM_A_REGS),
  localparam int PW    = $clog2(NUM_P_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  output logic                 alloc_ready_o,
  input  logic                 alloc0_valid_i,
  input  logic                 alloc0_regwrite_i,
  input  logic [AW-1:0]        alloc0_rd_i,
  input  logic [PW-1:0]        alloc0_p_dest_i,
  input  logic [PW-1:0]        alloc0_old_dest_i,
  output logic [IDX_W-1:0]     alloc0_idx_o,
  input  logic                 alloc1_valid_i,
  input  logic                 alloc1_regwrite_i,
  input  logic [AW-1:0]        alloc1_rd_i,
  input  logic [PW-1:0]        alloc1_p_dest_i,
  input  logic [PW-1:0]        alloc1_old_dest_i,
  output logic [IDX_W-1:0]     alloc1_idx_o,
  input  logic                 cmpl0_valid_i,
  input  logic [IDX_W-1:0]     cmpl0_idx_i,
  input  logic [WORD_SIZE-1:0] cmpl0_val_i,
  input  logic                 cmpl1_valid_i,
  input  logic [IDX_W-1:0]     cmpl1_idx_i,
  input  logic [WORD_SIZE-1:0] cmpl1_val_i,
  output logic                 commit0_valid_o,
  output logic                 commit0_free_en_o,
  output logic [PW-1:0]        commit0_free_preg_o,
  output logic [AW-1:0]        commit0_rd_o,
  output logic [WORD_SIZE-1:0] commit0_val_o,
  output logic                 commit1_valid_o,
  output logic                 commit1_free_en_o,
  output logic [PW-1:0]        commit1_free_preg_o,
  output logic [AW-1:0]        commit1_rd_o,
  output logic [WORD_SIZE-1:0] commit1_val_o,
  input  logic [IDX_W-1:0]     fwd0_idx_i,
  output logic                 fwd0_ready_o,
  output logic [WORD_SIZE-1:0] fwd0_val_o,
  input  logic [IDX_W-1:0]     fwd1_idx_i,
  output logic                 fwd1_ready_o,
  output logic [WORD_SIZE-1:0] fwd1_val_o,
  output logic [IDX_W:0]       count_o
);

  localparam int PTR_W = IDX_W + 1;  // extra wrap bit distinguishes full from empty

  // Entry storage: status bits are reset, payload is not.
  logic [NUM_ROB_ENTRIES-1:0]                valid_q, valid_d;
  logic [NUM_ROB_ENTRIES-1:0]                done_q, done_d;
  logic [NUM_ROB_ENTRIES-1:0]                regwrite_q, regwrite_d;
  logic [NUM_ROB_ENTRIES-1:0][AW-1:0]        rd_q, rd_d;
  logic [NUM_ROB_ENTRIES-1:0][PW-1:0]        p_dest_q, p_dest_d;
  logic [NUM_ROB_ENTRIES-1:0][PW-1:0]        old_dest_q, old_dest_d;
  logic [NUM_ROB_ENTRIES-1:0][WORD_SIZE-1:0] val_q, val_d;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] count_q, count_d;

  // Per-slot views of the scalar ports.
  logic [1:0]                alloc_valid, alloc_take, alloc_regwrite;
  logic [1:0][AW-1:0]        alloc_rd;
  logic [1:0][PW-1:0]        alloc_p_dest, alloc_old_dest;
  logic [1:0][IDX_W-1:0]     alloc_slot_idx;
  logic [1:0]                cmpl_valid;
  logic [1:0][IDX_W-1:0]     cmpl_idx;
  logic [1:0][WORD_SIZE-1:0] cmpl_val;
  logic [1:0][IDX_W-1:0]     head_idx;
  logic [1:0]                commit_valid;
  logic [1:0]                ncommit;
  logic [1:0]                nalloc;
  logic [1:0]                commit_free_en;
  logic [1:0][PW-1:0]        commit_free_preg;
  logic [1:0][AW-1:0]        commit_rd;
  logic [1:0][WORD_SIZE-1:0] commit_val;
  logic [1:0][IDX_W-1:0]     fwd_idx;
  logic [1:0]                fwd_ready;
  logic [1:0][WORD_SIZE-1:0] fwd_val;
  logic                      rob_empty;

  // The physical destination travels with the entry but nothing downstream of retire reads it.
  logic unused_p_dest;
  assign unused_p_dest = ^p_dest_q;

  // Readiness uses the registered count only; retires in the same cycle are not credited.
  assign alloc_ready_o = (count_q <= PTR_W'(NUM_ROB_ENTRIES - 2));
  assign count_o       = count_q;
  assign rob_empty     = (head_q == tail_q);

  assign alloc_valid    = {alloc1_valid_i, alloc0_valid_i};
  assign alloc_take     = alloc_valid & {2{alloc_ready_o}};
  assign alloc_regwrite = {alloc1_regwrite_i, alloc0_regwrite_i};
  assign alloc_rd       = {alloc1_rd_i, alloc0_rd_i};
  assign alloc_p_dest   = {alloc1_p_dest_i, alloc0_p_dest_i};
  assign alloc_old_dest = {alloc1_old_dest_i, alloc0_old_dest_i};
  assign cmpl_valid     = {cmpl1_valid_i, cmpl0_valid_i};
  assign cmpl_idx       = {cmpl1_idx_i, cmpl0_idx_i};
  assign cmpl_val       = {cmpl1_val_i, cmpl0_val_i};
  assign fwd_idx        = {fwd1_idx_i, fwd0_idx_i};

  // Slot 1 takes slot 0's place when slot 0 is idle, keeping allocation dense.
  assign alloc_slot_idx[0] = tail_q[IDX_W-1:0];
  assign alloc_slot_idx[1] = tail_q[IDX_W-1:0] + IDX_W'(alloc0_valid_i);
  assign head_idx[0]       = head_q[IDX_W-1:0];
  assign head_idx[1]       = head_q[IDX_W-1:0] + IDX_W'(1);
  assign nalloc            = slot_count(alloc_take);

  assign alloc0_idx_o = alloc_slot_idx[0];
  assign alloc1_idx_o = alloc_slot_idx[1];

  rob_commit_select u_commit_select (
    .flush_i        (flush_i),
    .empty_i        (rob_empty),
    .head_valid_i   ({valid_q[head_idx[1]], valid_q[head_idx[0]]}),
    .head_done_i    ({done_q[head_idx[1]], done_q[head_idx[0]]}),
    .commit_valid_o (commit_valid),
    .ncommit_o      (ncommit)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot_view
    assign commit_free_en[gi]   = commit_valid[gi] & regwrite_q[head_idx[gi]];
    assign commit_free_preg[gi] = old_dest_q[head_idx[gi]];
    assign commit_rd[gi]        = rd_q[head_idx[gi]];
    assign commit_val[gi]       = val_q[head_idx[gi]];
    assign fwd_ready[gi]        = valid_q[fwd_idx[gi]] & done_q[fwd_idx[gi]];
    assign fwd_val[gi]          = val_q[fwd_idx[gi]];
  end

  assign commit0_valid_o     = commit_valid[0];
  assign commit0_free_en_o   = commit_free_en[0];
  assign commit0_free_preg_o = commit_free_preg[0];
  assign commit0_rd_o        = commit_rd[0];
  assign commit0_val_o       = commit_val[0];
  assign commit1_valid_o     = commit_valid[1];
  assign commit1_free_en_o   = commit_free_en[1];
  assign commit1_free_preg_o = commit_free_preg[1];
  assign commit1_rd_o        = commit_rd[1];
  assign commit1_val_o       = commit_val[1];
  assign fwd0_ready_o        = fwd_ready[0];
  assign fwd0_val_o          = fwd_val[0];
  assign fwd1_ready_o        = fwd_ready[1];
  assign fwd1_val_o          = fwd_val[1];

  // Next state: completions, then retire clears, then new allocations; flush wipes everything.
  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    p_dest_d   = p_dest_q;
    old_dest_d = old_dest_q;
    val_d      = val_q;
    head_d     = head_q + PTR_W'(ncommit);
    tail_d     = tail_q + PTR_W'(nalloc);
    count_d    = count_q + PTR_W'(nalloc) - PTR_W'(ncommit);
    // Port 1 is applied last so it wins a same-index collision.
    for (int s = 0; s < 2; s++) begin
      if (cmpl_valid[s] && valid_q[cmpl_idx[s]]) begin
        done_d[cmpl_idx[s]] = 1'b1;
        val_d[cmpl_idx[s]]  = cmpl_val[s];
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (commit_valid[s]) begin
        valid_d[head_idx[s]] = 1'b0;
        done_d[head_idx[s]]  = 1'b0;
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (alloc_take[s]) begin
        valid_d[alloc_slot_idx[s]]    = 1'b1;
        done_d[alloc_slot_idx[s]]     = 1'b0;
        regwrite_d[alloc_slot_idx[s]] = alloc_regwrite[s];
        rd_d[alloc_slot_idx[s]]       = alloc_rd[s];
        p_dest_d[alloc_slot_idx[s]]   = alloc_p_dest[s];
        old_dest_d[alloc_slot_idx[s]] = alloc_old_dest[s];
      end
    end
    if (flush_i) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Status bits and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    regwrite_q <= regwrite_d;
    rd_q       <= rd_d;
    p_dest_q   <= p_dest_d;
    old_dest_q <= old_dest_d;
    val_q      <= val_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        alloc_ready_o;
  logic        alloc0_valid_i, alloc0_regwrite_i, alloc1_valid_i, alloc1_regwrite_i;
  logic [4:0]  alloc0_rd_i, alloc1_rd_i;
  logic [5:0]  alloc0_p_dest_i, alloc0_old_dest_i, alloc1_p_dest_i, alloc1_old_dest_i;
  logic [3:0]  alloc0_idx_o, alloc1_idx_o;
  logic        cmpl0_valid_i, cmpl1_valid_i;
  logic [3:0]  cmpl0_idx_i, cmpl1_idx_i;
  logic [31:0] cmpl0_val_i, cmpl1_val_i;
  logic        commit0_valid_o, commit0_free_en_o, commit1_valid_o, commit1_free_en_o;
  logic [5:0]  commit0_free_preg_o, commit1_free_preg_o;
  logic [4:0]  commit0_rd_o, commit1_rd_o;
  logic [31:0] commit0_val_o, commit1_val_o;
  logic [3:0]  fwd0_idx_i, fwd1_idx_i;
  logic        fwd0_ready_o, fwd1_ready_o;
  logic [31:0] fwd0_val_o, fwd1_val_o;
  logic [4:0]  count_o;

  int n_cmp = 0;
  int n_bad = 0;

  reorder_buffer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .alloc_ready_o(alloc_ready_o),
    .alloc0_valid_i(alloc0_valid_i), .alloc0_regwrite_i(alloc0_regwrite_i), .alloc0_rd_i(alloc0_rd_i),
    .alloc0_p_dest_i(alloc0_p_dest_i), .alloc0_old_dest_i(alloc0_old_dest_i), .alloc0_idx_o(alloc0_idx_o),
    .alloc1_valid_i(alloc1_valid_i), .alloc1_regwrite_i(alloc1_regwrite_i), .alloc1_rd_i(alloc1_rd_i),
    .alloc1_p_dest_i(alloc1_p_dest_i), .alloc1_old_dest_i(alloc1_old_dest_i), .alloc1_idx_o(alloc1_idx_o),
    .cmpl0_valid_i(cmpl0_valid_i), .cmpl0_idx_i(cmpl0_idx_i), .cmpl0_val_i(cmpl0_val_i),
    .cmpl1_valid_i(cmpl1_valid_i), .cmpl1_idx_i(cmpl1_idx_i), .cmpl1_val_i(cmpl1_val_i),
    .commit0_valid_o(commit0_valid_o), .commit0_free_en_o(commit0_free_en_o),
    .commit0_free_preg_o(commit0_free_preg_o), .commit0_rd_o(commit0_rd_o), .commit0_val_o(commit0_val_o),
    .commit1_valid_o(commit1_valid_o), .commit1_free_en_o(commit1_free_en_o),
    .commit1_free_preg_o(commit1_free_preg_o), .commit1_rd_o(commit1_rd_o), .commit1_val_o(commit1_val_o),
    .fwd0_idx_i(fwd0_idx_i), .fwd0_ready_o(fwd0_ready_o), .fwd0_val_o(fwd0_val_o),
    .fwd1_idx_i(fwd1_idx_i), .fwd1_ready_o(fwd1_ready_o), .fwd1_val_o(fwd1_val_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    flush_i = 0;
    alloc0_valid_i = 0; alloc1_valid_i = 0; cmpl0_valid_i = 0; cmpl1_valid_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_alloc(input logic v0, input logic v1, input logic [4:0] rd0, input logic [4:0] rd1,
                           input logic [5:0] pd0, input logic [5:0] pd1,
                           input logic [5:0] od0, input logic [5:0] od1);
    alloc0_valid_i = v0; alloc0_regwrite_i = 1; alloc0_rd_i = rd0; alloc0_p_dest_i = pd0; alloc0_old_dest_i = od0;
    alloc1_valid_i = v1; alloc1_regwrite_i = 1; alloc1_rd_i = rd1; alloc1_p_dest_i = pd1; alloc1_old_dest_i = od1;
  endtask

  task automatic test_reset();
    rst_ni = 0; idle();
    alloc0_regwrite_i = 0; alloc1_regwrite_i = 0; alloc0_rd_i = 0; alloc1_rd_i = 0;
    alloc0_p_dest_i = 0; alloc1_p_dest_i = 0; alloc0_old_dest_i = 0; alloc1_old_dest_i = 0;
    cmpl0_idx_i = 0; cmpl1_idx_i = 0; cmpl0_val_i = 0; cmpl1_val_i = 0; fwd0_idx_i = 0; fwd1_idx_i = 0;
    #3;
    n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_alloc_ready got=%b want=1", alloc_ready_o); end
    n_cmp++; if ({commit1_valid_o, commit0_valid_o} !== 2'b00) begin n_bad++; $display("FAIL reset_commit got=%b want=00", {commit1_valid_o, commit0_valid_o}); end
    n_cmp++; if (fwd0_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_fwd_ready got=%b want=0", fwd0_ready_o); end
    step();
    rst_ni = 1;
    $display("reset: count=%0d ready=%b", count_o, alloc_ready_o);
  endtask

  task automatic test_out_of_order_complete();
    set_alloc(1, 1, 5'd1, 5'd2, 6'd33, 6'd34, 6'd3, 6'd4);
    #1;
    n_cmp++; if ({alloc1_idx_o, alloc0_idx_o} !== {4'd1, 4'd0}) begin n_bad++; $display("FAIL ooo_alloc_idx got=%0d,%0d want=0,1", alloc0_idx_o, alloc1_idx_o); end
    step(); idle(); #1;
    n_cmp++; if (count_o !== 5'd2) begin n_bad++; $display("FAIL ooo_count got=%0d want=2", count_o); end
    cmpl1_valid_i = 1; cmpl1_idx_i = 4'd1; cmpl1_val_i = 32'hB1; fwd1_idx_i = 4'd1;
    step(); cmpl1_valid_i = 0; #1;
    n_cmp++; if (commit0_valid_o !== 1'b0) begin n_bad++; $display("FAIL ooo_no_retire got=%b want=0", commit0_valid_o); end
    n_cmp++; if ({fwd1_ready_o, fwd1_val_o} !== {1'b1, 32'hB1}) begin n_bad++; $display("FAIL ooo_fwd got=%b/%h want=1/b1", fwd1_ready_o, fwd1_val_o); end
    cmpl0_valid_i = 1; cmpl0_idx_i = 4'd0; cmpl0_val_i = 32'hA0; #1;
    n_cmp++; if (commit0_valid_o !== 1'b0) begin n_bad++; $display("FAIL ooo_no_bypass got=%b want=0", commit0_valid_o); end
    step(); cmpl0_valid_i = 0; #1;
    n_cmp++; if ({commit1_valid_o, commit0_valid_o, commit1_free_en_o, commit0_free_en_o} !== 4'b1111) begin n_bad++; $display("FAIL ooo_commit2 got=%b want=1111", {commit1_valid_o, commit0_valid_o, commit1_free_en_o, commit0_free_en_o}); end
    n_cmp++; if ({commit0_free_preg_o, commit1_free_preg_o} !== {6'd3, 6'd4}) begin n_bad++; $display("FAIL ooo_free_preg got=%0d,%0d want=3,4", commit0_free_preg_o, commit1_free_preg_o); end
    n_cmp++; if ({commit0_val_o, commit1_rd_o} !== {32'hA0, 5'd2}) begin n_bad++; $display("FAIL ooo_trace got=%h,%0d want=a0,2", commit0_val_o, commit1_rd_o); end
    step(); #1;
    n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL ooo_drain got=%0d want=0", count_o); end
    $display("out_of_order: retired pair freeing 3,4");
  endtask

  task automatic test_slot1_only_double_cmpl();
    set_alloc(0, 1, 5'd0, 5'd7, 6'd0, 6'd40, 6'd0, 6'd9);
    alloc1_regwrite_i = 0; #1;
    n_cmp++; if (alloc1_idx_o !== 4'd2) begin n_bad++; $display("FAIL slot1_idx got=%0d want=2", alloc1_idx_o); end
    step(); idle(); #1;
    n_cmp++; if (count_o !== 5'd1) begin n_bad++; $display("FAIL slot1_count got=%0d want=1", count_o); end
    cmpl0_valid_i = 1; cmpl0_idx_i = 4'd2; cmpl0_val_i = 32'h111;
    cmpl1_valid_i = 1; cmpl1_idx_i = 4'd2; cmpl1_val_i = 32'h222;
    step(); idle(); #1;
    n_cmp++; if ({commit1_valid_o, commit0_valid_o} !== 2'b01) begin n_bad++; $display("FAIL dbl_commit got=%b want=01", {commit1_valid_o, commit0_valid_o}); end
    n_cmp++; if (commit0_val_o !== 32'h222) begin n_bad++; $display("FAIL dbl_port1_wins got=%h want=222", commit0_val_o); end
    n_cmp++; if ({commit0_free_en_o, commit0_rd_o} !== {1'b0, 5'd7}) begin n_bad++; $display("FAIL dbl_no_regwrite got=%b,%0d want=0,7", commit0_free_en_o, commit0_rd_o); end
    step(); #1;
    n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL dbl_drain got=%0d want=0", count_o); end
    $display("slot1_only: idx=2 val=%h", 32'h222);
  endtask

  task automatic test_fill();
    for (int k = 0; k < 7; k++) begin
      int t0;
      int t1;
      t0 = (3 + 2 * k) % 16;
      t1 = (4 + 2 * k) % 16;
      set_alloc(1, 1, t0[4:0], t1[4:0], 6'd40, 6'd41, t0[5:0], t1[5:0]);
      #1;
      if (k == 0) begin
        n_cmp++; if (alloc0_idx_o !== 4'd3) begin n_bad++; $display("FAIL fill_first_idx got=%0d want=3", alloc0_idx_o); end
      end
      step();
    end
    idle(); #1;
    n_cmp++; if ({count_o, alloc_ready_o} !== {5'd14, 1'b1}) begin n_bad++; $display("FAIL fill_14 got=%0d/%b want=14/1", count_o, alloc_ready_o); end
    set_alloc(1, 0, 5'd1, 5'd0, 6'd40, 6'd0, 6'd1, 6'd0);
    step(); idle(); #1;
    n_cmp++; if ({count_o, alloc_ready_o} !== {5'd15, 1'b0}) begin n_bad++; $display("FAIL fill_15 got=%0d/%b want=15/0", count_o, alloc_ready_o); end
    set_alloc(1, 1, 5'd9, 5'd9, 6'd50, 6'd51, 6'd60, 6'd61);
    step(); idle(); #1;
    n_cmp++; if (count_o !== 5'd15) begin n_bad++; $display("FAIL fill_drop got=%0d want=15", count_o); end
    $display("fill: count=15 ready=0 extra pair dropped");
  endtask

  task automatic test_wrap_retire();
    for (int i = 3; i <= 13; i += 2) begin
      int j;
      j = i + 1;
      cmpl0_valid_i = 1; cmpl0_idx_i = i[3:0]; cmpl0_val_i = 32'h100 + 32'(i);
      cmpl1_valid_i = (j <= 13); cmpl1_idx_i = j[3:0]; cmpl1_val_i = 32'h100 + 32'(j);
      step();
    end
    idle();
    for (int c = 0; c < 20 && count_o != 5'd4; c++) step();
    n_cmp++; if ({count_o, commit0_valid_o} !== {5'd4, 1'b0}) begin n_bad++; $display("FAIL wrap_head14 got=%0d/%b want=4/0", count_o, commit0_valid_o); end
    cmpl0_valid_i = 1; cmpl0_idx_i = 4'd14; cmpl0_val_i = 32'h10E;
    cmpl1_valid_i = 1; cmpl1_idx_i = 4'd15; cmpl1_val_i = 32'h10F;
    step();
    cmpl0_idx_i = 4'd0; cmpl0_val_i = 32'h100;
    cmpl1_idx_i = 4'd1; cmpl1_val_i = 32'h101; #1;
    n_cmp++; if ({commit1_valid_o, commit0_valid_o} !== 2'b11) begin n_bad++; $display("FAIL wrap_commit_a got=%b want=11", {commit1_valid_o, commit0_valid_o}); end
    n_cmp++; if ({commit0_val_o, commit1_val_o} !== {32'h10E, 32'h10F}) begin n_bad++; $display("FAIL wrap_order_a got=%h,%h want=10e,10f", commit0_val_o, commit1_val_o); end
    n_cmp++; if ({commit0_free_preg_o, commit1_free_preg_o} !== {6'd14, 6'd15}) begin n_bad++; $display("FAIL wrap_preg_a got=%0d,%0d want=14,15", commit0_free_preg_o, commit1_free_preg_o); end
    step(); idle(); #1;
    n_cmp++; if (count_o !== 5'd2) begin n_bad++; $display("FAIL wrap_count2 got=%0d want=2", count_o); end
    n_cmp++; if ({commit0_val_o, commit1_val_o} !== {32'h100, 32'h101}) begin n_bad++; $display("FAIL wrap_order_b got=%h,%h want=100,101", commit0_val_o, commit1_val_o); end
    n_cmp++; if (commit1_free_preg_o !== 6'd1) begin n_bad++; $display("FAIL wrap_preg_b got=%0d want=1", commit1_free_preg_o); end
    step(); #1;
    n_cmp++; if ({count_o, commit0_valid_o, alloc_ready_o} !== {5'd0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL wrap_empty got=%0d/%b/%b want=0/0/1", count_o, commit0_valid_o, alloc_ready_o); end
    $display("wrap: retired 14,15,0,1");
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      set_alloc(1, 1, 5'd3, 5'd4, 6'd20, 6'd21, 6'd22, 6'd23);
      step();
    end
    idle(); #1;
    n_cmp++; if (count_o !== 5'd6) begin n_bad++; $display("FAIL flush_pre_count got=%0d want=6", count_o); end
    cmpl0_valid_i = 1; cmpl0_idx_i = 4'd2; cmpl0_val_i = 32'h55;
    step(); idle(); #1;
    n_cmp++; if (commit0_valid_o !== 1'b1) begin n_bad++; $display("FAIL flush_pre_commit got=%b want=1", commit0_valid_o); end
    flush_i = 1; cmpl0_valid_i = 1; cmpl0_idx_i = 4'd3; cmpl0_val_i = 32'h66; fwd0_idx_i = 4'd3; #1;
    n_cmp++; if ({commit0_valid_o, commit0_free_en_o} !== 2'b00) begin n_bad++; $display("FAIL flush_commit_mask got=%b want=00", {commit0_valid_o, commit0_free_en_o}); end
    step(); idle(); #1;
    n_cmp++; if ({count_o, alloc0_idx_o, commit0_valid_o, fwd0_ready_o} !== {5'd0, 4'd0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL flush_clear got=%0d/%0d/%b/%b want=0/0/0/0", count_o, alloc0_idx_o, commit0_valid_o, fwd0_ready_o); end
    set_alloc(1, 1, 5'd5, 5'd6, 6'd30, 6'd31, 6'd11, 6'd12); #1;
    n_cmp++; if (alloc1_idx_o !== 4'd1) begin n_bad++; $display("FAIL flush_tail got=%0d want=1", alloc1_idx_o); end
    step(); idle();
    cmpl0_valid_i = 1; cmpl0_idx_i = 4'd0; cmpl0_val_i = 32'h77;
    step(); idle(); #1;
    n_cmp++; if ({commit0_valid_o, commit0_val_o, commit0_free_preg_o} !== {1'b1, 32'h77, 6'd11}) begin n_bad++; $display("FAIL flush_head0 got=%b/%h/%0d want=1/77/11", commit0_valid_o, commit0_val_o, commit0_free_preg_o); end
    flush_i = 1; step(); idle();
    $display("flush: cleared 6 live entries");
  endtask

  task automatic test_reset_mid_run();
    set_alloc(1, 1, 5'd1, 5'd2, 6'd40, 6'd41, 6'd42, 6'd43); step();
    set_alloc(1, 1, 5'd3, 5'd4, 6'd44, 6'd45, 6'd46, 6'd47); step();
    set_alloc(1, 0, 5'd5, 5'd0, 6'd48, 6'd0, 6'd49, 6'd0); step();
    idle();
    cmpl0_valid_i = 1; cmpl0_idx_i = 4'd0; cmpl0_val_i = 32'h99; fwd0_idx_i = 4'd0;
    step(); idle(); #1;
    n_cmp++; if ({count_o, commit0_valid_o} !== {5'd5, 1'b1}) begin n_bad++; $display("FAIL rst_pre got=%0d/%b want=5/1", count_o, commit0_valid_o); end
    #2; rst_ni = 0; #1;
    n_cmp++; if ({count_o, alloc_ready_o, commit0_valid_o, fwd0_ready_o} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL rst_mid got=%0d/%b/%b/%b want=0/1/0/0", count_o, alloc_ready_o, commit0_valid_o, fwd0_ready_o); end
    #2; rst_ni = 1;
    step();
    set_alloc(1, 0, 5'd8, 5'd0, 6'd50, 6'd0, 6'd51, 6'd0); #1;
    n_cmp++; if (alloc0_idx_o !== 4'd0) begin n_bad++; $display("FAIL rst_tail got=%0d want=0", alloc0_idx_o); end
    step(); idle(); #1;
    n_cmp++; if ({count_o, commit0_valid_o} !== {5'd1, 1'b0}) begin n_bad++; $display("FAIL rst_wait got=%0d/%b want=1/0", count_o, commit0_valid_o); end
    cmpl0_valid_i = 1; cmpl0_idx_i = 4'd0; cmpl0_val_i = 32'h88;
    step(); idle(); #1;
    n_cmp++; if ({commit0_valid_o, commit0_val_o, commit0_free_preg_o} !== {1'b1, 32'h88, 6'd51}) begin n_bad++; $display("FAIL rst_new_commit got=%b/%h/%0d want=1/88/51", commit0_valid_o, commit0_val_o, commit0_free_preg_o); end
    step(); #1;
    n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL rst_drain got=%0d want=0", count_o); end
    $display("reset_mid_run: 5 live entries discarded");
  endtask

  initial begin
    test_reset();
    test_out_of_order_complete();
    test_slot1_only_double_cmpl();
    test_fill();
    test_wrap_retire();
    test_flush();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
